// File: rtl/wb_arbiter_pkg.sv
// Shared widths, FIFO entry type and round-robin helper for the writeback arbiter.
package wb_arbiter_pkg;

  localparam int WORD  = 32;
  localparam int NREG  = 32;
  localparam int RADDR = 5;

  typedef struct packed {
    logic [RADDR-1:0] rd;
    logic [WORD-1:0]  data;
  } wb_entry_t;

  // Wrap v into [0, n) for v < 2*n.
  function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO: DEPTH entries of {rd, data}, head visible combinationally.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  wb_entry_t                    din,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output wb_entry_t                    head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin over per-source FIFOs into a held output register.
// Optional WB_BYPASS_EN adds same-cycle forwarding outputs.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  output logic [NUM_SRC-1:0]       src_ready_o,
  input  logic [NUM_SRC*RADDR-1:0] src_rd_i,
  input  logic [NUM_SRC*WORD-1:0]  src_data_i,
  input  logic [NREG-1:0]          rsv_i,
  output logic [NREG-1:0]          wb_o,
  output logic [WORD-1:0]          wb_data_o,
`ifdef WB_BYPASS_EN
  output logic                     byp_valid_o,
  output logic [RADDR-1:0]         byp_rd_o,
  output logic [WORD-1:0]          byp_data_o,
`endif
  output logic [RADDR-1:0]         wb_rd_o
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_empty;
  logic [CW-1:0]      w_count [NUM_SRC];
  wb_entry_t          w_head  [NUM_SRC];

  logic               r_out_busy;
  logic [RADDR-1:0]   r_wb_rd;
  logic [WORD-1:0]    r_wb_data;
  logic [SW-1:0]      r_rr_ptr;

  logic               w_hold;
  logic               w_gnt_valid;
  logic [SW-1:0]      w_gnt_idx;
  wb_entry_t          w_gnt_entry;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      wb_entry_t w_din;
      assign w_din.rd      = src_rd_i[gi*RADDR +: RADDR];
      assign w_din.data    = src_data_i[gi*WORD +: WORD];
      assign src_ready_o[gi] = (w_count[gi] != CW'(FIFO_DEPTH));
      assign w_push[gi]    = src_valid_i[gi] & ~w_full[gi];
      assign w_pop[gi]     = w_gnt_valid & (w_gnt_idx == SW'(gi));

      wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push[gi]),
        .pop   (w_pop[gi]),
        .din   (w_din),
        .full  (w_full[gi]),
        .empty (w_empty[gi]),
        .count (w_count[gi]),
        .head  (w_head[gi])
      );
    end
  endgenerate

  // A reserved target would be dropped by the cell, so the entry stays put.
  assign w_hold = r_out_busy & rsv_i[r_wb_rd];

  // Scan from the highest offset down so the nearest non-empty source wins.
  always_comb begin
    int unsigned k;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    k           = 0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      k = rr_wrap(int'(r_rr_ptr) + i, NUM_SRC);
      if (!w_empty[k]) begin
        w_gnt_valid = ~w_hold;
        w_gnt_idx   = SW'(k);
      end
    end
    w_gnt_entry = w_head[w_gnt_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_busy <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_rr_ptr   <= '0;
    end else if (!w_hold) begin
      if (w_gnt_valid) begin
        r_rr_ptr   <= SW'(rr_wrap(int'(w_gnt_idx) + 1, NUM_SRC));
        // rd 0 is the zero register: the slot is consumed but nothing is written.
        r_out_busy <= (w_gnt_entry.rd != '0);
        if (w_gnt_entry.rd != '0) begin
          r_wb_rd   <= w_gnt_entry.rd;
          r_wb_data <= w_gnt_entry.data;
        end
      end else begin
        r_out_busy <= 1'b0;
      end
    end
  end

  generate
    for (gi = 0; gi < NREG; gi++) begin : g_dec
      assign wb_o[gi] = r_out_busy & (r_wb_rd == RADDR'(gi));
    end
  endgenerate

  assign wb_data_o = r_wb_data;
  assign wb_rd_o   = r_wb_rd;

`ifdef WB_BYPASS_EN
  assign byp_valid_o = r_out_busy & ~rsv_i[r_wb_rd];
  assign byp_rd_o    = r_wb_rd;
  assign byp_data_o  = r_wb_data;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (3 sources, depth-2 FIFOs).
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NS = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NS-1:0]         src_valid_i = '0;
  logic [NS-1:0]         src_ready_o;
  logic [NS*RADDR-1:0]   src_rd_i = '0;
  logic [NS*WORD-1:0]    src_data_i = '0;
  logic [NREG-1:0]       rsv_i = '0;
  logic [NREG-1:0]       wb_o;
  logic [WORD-1:0]       wb_data_o;
  logic [RADDR-1:0]      wb_rd_o;
`ifdef WB_BYPASS_EN
  logic                  byp_valid_o;
  logic [RADDR-1:0]      byp_rd_o;
  logic [WORD-1:0]       byp_data_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  wb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .src_rd_i    (src_rd_i),
    .src_data_i  (src_data_i),
    .rsv_i       (rsv_i),
    .wb_o        (wb_o),
    .wb_data_o   (wb_data_o),
`ifdef WB_BYPASS_EN
    .byp_valid_o (byp_valid_o),
    .byp_rd_o    (byp_rd_o),
    .byp_data_o  (byp_data_o),
`endif
    .wb_rd_o     (wb_rd_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [63:0] oh(input int r);
    logic [63:0] v;
    v = 64'h1 << r;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [RADDR-1:0] rd, input logic [WORD-1:0] d);
    src_valid_i[s]               = v;
    src_rd_i[s*RADDR +: RADDR]   = rd;
    src_data_i[s*WORD +: WORD]   = d;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    src_valid_i = '0;
    rsv_i       = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // 1: reset state and a single push with two-cycle latency
    #2;
    check_vec("rst_wb", 64'(wb_o), 64'h0);
    check_vec("rst_ready", 64'(src_ready_o), 64'h7);
    do_reset();
    set_src(0, 1'b1, 5'd5, 32'hA5A5_0001);
    tick();
    src_valid_i = '0;
    check_vec("t1_wb_early", 64'(wb_o), 64'h0);
    tick();
    check_vec("t1_wb", 64'(wb_o), oh(5));
    check_vec("t1_data", 64'(wb_data_o), 64'hA5A5_0001);
    check_vec("t1_rd", 64'(wb_rd_o), 64'd5);
    tick();
    check_vec("t1_wb_off", 64'(wb_o), 64'h0);

    // 2: simultaneous pushes drain in source order
    do_reset();
    set_src(0, 1'b1, 5'd1, 32'hD000_0000);
    set_src(1, 1'b1, 5'd2, 32'hD000_0001);
    set_src(2, 1'b1, 5'd3, 32'hD000_0002);
    tick();
    src_valid_i = '0;
    check_vec("t2_wb0", 64'(wb_o), 64'h0);
    tick();
    check_vec("t2_src0", 64'(wb_o), oh(1));
    check_vec("t2_d0", 64'(wb_data_o), 64'hD000_0000);
    tick();
    check_vec("t2_src1", 64'(wb_o), oh(2));
    check_vec("t2_d1", 64'(wb_data_o), 64'hD000_0001);
    tick();
    check_vec("t2_src2", 64'(wb_o), oh(3));
    check_vec("t2_d2", 64'(wb_data_o), 64'hD000_0002);
    tick();
    check_vec("t2_idle", 64'(wb_o), 64'h0);
    check_vec("t2_rr", 64'(dut.r_rr_ptr), 64'd0);

    // 3: back-pressure while the head writeback is reserve-blocked
    do_reset();
    rsv_i = 32'h1 << 9;
    set_src(1, 1'b1, 5'd9, 32'h0000_0009);
    tick();
    check_vec("t3_ready_a", 64'(src_ready_o[1]), 64'd1);
    check_vec("t3_wb_a", 64'(wb_o), 64'h0);
    set_src(1, 1'b1, 5'd10, 32'h0000_000A);
    tick();
    check_vec("t3_hold_a", 64'(wb_o), oh(9));
    check_vec("t3_ready_b", 64'(src_ready_o[1]), 64'd1);
    set_src(1, 1'b1, 5'd11, 32'h0000_000B);
    tick();
    check_vec("t3_hold_b", 64'(wb_o), oh(9));
    check_vec("t3_ready_c", 64'(src_ready_o[1]), 64'd0);
    set_src(1, 1'b1, 5'd12, 32'h0000_000C);
    tick();
    check_vec("t3_hold_c", 64'(wb_o), oh(9));
    check_vec("t3_ready_d", 64'(src_ready_o[1]), 64'd0);
    src_valid_i = '0;
    tick();
    check_vec("t3_hold_d", 64'(wb_o), oh(9));
    check_vec("t3_hold_data", 64'(wb_data_o), 64'h9);
    rsv_i = '0;
    tick();
    check_vec("t3_drain_a", 64'(wb_o), oh(10));
    check_vec("t3_drain_ad", 64'(wb_data_o), 64'hA);
    check_vec("t3_ready_e", 64'(src_ready_o[1]), 64'd1);
    tick();
    check_vec("t3_drain_b", 64'(wb_o), oh(11));
    check_vec("t3_drain_bd", 64'(wb_data_o), 64'hB);
    tick();
    check_vec("t3_empty", 64'(wb_o), 64'h0);

    // 4: two reserved cycles stretch wb_o[7] to three and block src1
    do_reset();
    set_src(0, 1'b1, 5'd7, 32'h7777_0007);
    set_src(1, 1'b1, 5'd8, 32'h8888_0008);
    tick();
    src_valid_i = '0;
    rsv_i = 32'h1 << 7;
    check_vec("t4_wb0", 64'(wb_o), 64'h0);
    tick();
    check_vec("t4_r7_a", 64'(wb_o), oh(7));
`ifdef WB_BYPASS_EN
    check_vec("t4_byp_hold", 64'(byp_valid_o), 64'd0);
`endif
    tick();
    check_vec("t4_r7_b", 64'(wb_o), oh(7));
    check_vec("t4_d_b", 64'(wb_data_o), 64'h7777_0007);
    tick();
    check_vec("t4_r7_c", 64'(wb_o), oh(7));
    check_vec("t4_d_c", 64'(wb_data_o), 64'h7777_0007);
    rsv_i = '0;
`ifdef WB_BYPASS_EN
    #1;
    check_vec("t4_byp_go", 64'(byp_valid_o), 64'd1);
`endif
    tick();
    check_vec("t4_r8", 64'(wb_o), oh(8));
    check_vec("t4_d8", 64'(wb_data_o), 64'h8888_0008);
    tick();
    check_vec("t4_idle", 64'(wb_o), 64'h0);

    // 5: rd=0 consumes a grant slot without a writeback
    do_reset();
    set_src(2, 1'b1, 5'd0, 32'hDEAD_0000);
    tick();
    set_src(2, 1'b1, 5'd4, 32'h0000_4444);
    check_vec("t5_wb_a", 64'(wb_o), 64'h0);
    tick();
    src_valid_i = '0;
    check_vec("t5_r0_none", 64'(wb_o), 64'h0);
    tick();
    check_vec("t5_r4", 64'(wb_o), oh(4));
    check_vec("t5_d4", 64'(wb_data_o), 64'h0000_4444);
    tick();
    check_vec("t5_idle", 64'(wb_o), 64'h0);
    check_vec("t5_rr", 64'(dut.r_rr_ptr), 64'd0);

    // 6: asynchronous reset discards buffered and pending writebacks
    do_reset();
    set_src(0, 1'b1, 5'd1, 32'h1);
    set_src(1, 1'b1, 5'd2, 32'h2);
    set_src(2, 1'b1, 5'd3, 32'h3);
    tick();
    set_src(0, 1'b1, 5'd4, 32'h4);
    set_src(1, 1'b1, 5'd5, 32'h5);
    set_src(2, 1'b1, 5'd6, 32'h6);
    tick();
    src_valid_i = '0;
    check_vec("t6_pre", 64'(wb_o), oh(1));
    rst = 1'b0;
    #1;
    check_vec("t6_wb_rst", 64'(wb_o), 64'h0);
    check_vec("t6_data_rst", 64'(wb_data_o), 64'h0);
    check_vec("t6_rd_rst", 64'(wb_rd_o), 64'h0);
    check_vec("t6_ready_rst", 64'(src_ready_o), 64'h7);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_vec($sformatf("t6_stale_%0d", c), 64'(wb_o), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
